// File: rtl/spi_reg_bank_pkg.sv
// spi_reg_pkg: shared FSM state type and frame geometry for the SPI register bank.
package spi_reg_pkg;

    localparam int ADDR_W  = 7;
    localparam int HDR_LEN = 8;

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    function automatic int frame_len(input int dataW);
        return HDR_LEN + dataW;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchroniser for one async SPI line,
// followed by an edge-detect flop that yields 1-clk rise/fall strobes.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Chain resets low so a line held low through reset never produces a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign q    = r_sync[SYNC_STAGES-1];
    assign rise = q & ~r_prev;
    assign fall = ~q & r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral exposing NUM_REGS x DATA_W control registers.
// Define SPI_READBACK_EN to build the cipo read path; otherwise cipo is tied low.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                NUM_REGS    = 5,
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         copi,
    output logic                         cipo,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_LEN = frame_len(DATA_W);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int SHREG_W   = (DATA_W > HDR_LEN) ? DATA_W : HDR_LEN;

    localparam logic [CNT_W-1:0]  CNT_HDR_LAST   = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_HDR        = CNT_W'(HDR_LEN);
    localparam logic [CNT_W-1:0]  CNT_FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FRAME      = CNT_W'(FRAME_LEN);
    localparam logic [ADDR_W:0]   NUM_REGS_EXT   = (ADDR_W + 1)'(NUM_REGS);

    logic w_sclkQ, w_sclkRise, w_sclkFall;
    logic w_csQ, w_csRise, w_csFall;
    logic w_copiQ, w_copiRise, w_copiFall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_syncSclk (
        .clk(clk), .rst(rst), .d_async(sclk),
        .q(w_sclkQ), .rise(w_sclkRise), .fall(w_sclkFall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_syncCs (
        .clk(clk), .rst(rst), .d_async(cs_n),
        .q(w_csQ), .rise(w_csRise), .fall(w_csFall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_syncCopi (
        .clk(clk), .rst(rst), .d_async(copi),
        .q(w_copiQ), .rise(w_copiRise), .fall(w_copiFall)
    );

    state_t              r_state, w_nextState;
    logic [CNT_W-1:0]    r_bitCnt;
    logic [SHREG_W-1:0]  r_shreg, w_shiftVal;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_overrun;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic w_frameEnd, w_shift, w_cntFull, w_addrOk, w_commit, w_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // A cs_n rise outranks a simultaneous sclk rise, so that edge is dropped.
    always_comb begin
        w_nextState = r_state;
        w_shiftVal  = {r_shreg[SHREG_W-2:0], w_copiQ};
        w_frameEnd  = (r_state != IDLE) && w_csRise;
        w_shift     = (r_state != IDLE) && !w_csRise && w_sclkRise;
        w_cntFull   = (r_bitCnt == CNT_FRAME);
        w_addrOk    = ({1'b0, r_addr} < NUM_REGS_EXT);
        w_commit    = w_frameEnd && r_rw && w_cntFull && !r_overrun && w_addrOk;
        w_err       = w_frameEnd && !w_commit && !(!r_rw && w_cntFull && !r_overrun);
        case (r_state)
            IDLE: if (w_csFall) w_nextState = HDR;
            HDR: begin
                if (w_csRise)                                   w_nextState = IDLE;
                else if (w_sclkRise && r_bitCnt == CNT_HDR_LAST) w_nextState = DATA;
            end
            DATA: begin
                if (w_csRise)                                     w_nextState = IDLE;
                else if (w_sclkRise && r_bitCnt == CNT_FRAME_LAST) w_nextState = DONE;
            end
            DONE: if (w_csRise) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt  <= '0;
            r_shreg   <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else begin
            wr_pulse  <= w_commit;
            frame_err <= w_err;
            if (r_state == IDLE && w_csFall) begin
                r_bitCnt  <= '0;
                r_shreg   <= '0;
                r_rw      <= 1'b0;
                r_addr    <= '0;
                r_overrun <= 1'b0;
            end else if (w_shift) begin
                if (r_state == DONE) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_shreg  <= w_shiftVal;
                    r_bitCnt <= r_bitCnt + 1'b1;
                    if (r_state == HDR && r_bitCnt == CNT_HDR_LAST) begin
                        r_rw   <= w_shiftVal[HDR_LEN-1];
                        r_addr <= w_shiftVal[ADDR_W-1:0];
                    end
                end
            end
            if (w_commit) wr_addr <= r_addr;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && r_addr == ADDR_W'(i)) r_regs[i] <= r_shreg[DATA_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regsOut
        assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
    end

    logic w_unused;
    assign w_unused = ^{w_sclkQ, w_csQ, w_copiRise, w_copiFall, r_shreg[SHREG_W-1]};

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] r_tx, w_rdVal;
    logic              r_cipo;

    always_comb begin
        w_rdVal = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_addr == ADDR_W'(i)) w_rdVal = r_regs[i];
        end
    end

    // Load on the first sclk fall after header bit 8, then shift on every later fall.
    always_ff @(posedge clk) begin
        if (rst || w_frameEnd) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (w_sclkFall && !r_rw && r_state == DATA && r_bitCnt == CNT_HDR) begin
            r_cipo <= w_rdVal[DATA_W-1];
            r_tx   <= w_rdVal << 1;
        end else if (w_sclkFall && !r_rw && (r_state == DATA || r_state == DONE)
                     && r_bitCnt > CNT_HDR) begin
            r_cipo <= r_tx[DATA_W-1];
            r_tx   <= r_tx << 1;
        end
    end

    assign cipo = r_cipo;
`else
    logic w_unusedRb;
    assign w_unusedRb = w_sclkFall;
    assign cipo       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed SPI frames against a register-bank model, with a
// per-cycle compare process and literal expectations for the key frames.
module tb_spi_reg_bank;

    localparam int HALF   = 6;
    localparam int SETTLE = 12;
    localparam int NR     = 5;
    localparam int FL     = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk = 1'b0, cs_n = 1'b1, copi = 1'b0;
    logic         cipo;
    logic [39:0]  regs_out;
    logic         wr_pulse, frame_err;
    logic [6:0]   wr_addr;

    logic         sclk2 = 1'b0, cs2_n = 1'b1, copi2 = 1'b0;
    logic         cipo2;
    logic [319:0] regs_out2;
    logic         wr_pulse2, frame_err2;
    logic [6:0]   wr_addr2;

    int checks = 0;
    int errors = 0;
    int wrCount = 0, errCount = 0, wrCount2 = 0, errCount2 = 0;
    int expWr = 0, expErr = 0;
    logic [7:0] expRegs [NR];
    logic [6:0] expWrAddr = 7'd0;
    logic       checkEn = 1'b0;

    spi_reg_bank #(.NUM_REGS(5), .DATA_W(8), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .copi(copi), .cipo(cipo),
        .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    spi_reg_bank #(.NUM_REGS(20), .DATA_W(16), .SYNC_STAGES(2), .RESET_VAL(16'h0000)) dut2 (
        .clk(clk), .rst(rst), .sclk(sclk2), .cs_n(cs2_n), .copi(copi2), .cipo(cipo2),
        .regs_out(regs_out2), .wr_pulse(wr_pulse2), .wr_addr(wr_addr2), .frame_err(frame_err2)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] packModel();
        logic [39:0] v;
        v = '0;
        for (int r = 0; r < NR; r++) v[r*8 +: 8] = expRegs[r];
        return v;
    endfunction

    // Pulse counters plus the per-cycle register/cipo comparison.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_pulse)   wrCount++;
            if (frame_err)  errCount++;
            if (wr_pulse2)  wrCount2++;
            if (frame_err2) errCount2++;
        end
        if (checkEn) begin
            checkOutput("regsOut", regs_out, packModel());
`ifdef SPI_READBACK_EN
            if (cs_n) checkOutput("cipoIdle", cipo, 1'b0);
`else
            checkOutput("cipoTied", cipo, 1'b0);
`endif
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setCs(input int d, input logic v);
        if (d == 0) cs_n = v; else cs2_n = v;
    endtask

    task automatic spiBits(input int d, input logic [23:0] full, input int nbits,
                           input int flen, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = (i < flen) ? full[flen-1-i] : 1'b1;
            if (d == 0) copi = b; else copi2 = b;
            waitClk(HALF);
            if (i >= 8 && i < flen) rx[flen-1-i] = (d == 0) ? cipo : cipo2;
            if (d == 0) sclk = 1'b1; else sclk2 = 1'b1;
            waitClk(HALF);
            if (d == 0) sclk = 1'b0; else sclk2 = 1'b0;
        end
        waitClk(HALF);
    endtask

    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                                 input int nbits, output logic [7:0] rxOut);
        logic [15:0] rx;
        logic [7:0]  expRx;
        logic        okLen;
        setCs(0, 1'b0);
        waitClk(HALF);
        spiBits(0, {8'h00, rw, addr, data}, nbits, FL, rx);
        checkEn = 1'b0;
        setCs(0, 1'b1);
        waitClk(SETTLE);
        okLen = (nbits == FL);
`ifdef SPI_READBACK_EN
        expRx = (int'(addr) < NR) ? expRegs[int'(addr)] : 8'h00;
`else
        expRx = 8'h00;
`endif
        if (rw && okLen && int'(addr) < NR) begin
            expRegs[int'(addr)] = data;
            expWr++;
            expWrAddr = addr;
        end else if (!(!rw && okLen)) begin
            expErr++;
        end
        checkEn = 1'b1;
        checkOutput("wrPulses", wrCount, expWr);
        checkOutput("errPulses", errCount, expErr);
        checkOutput("wrAddr", wr_addr, expWrAddr);
        if (!rw && okLen) checkOutput("readData", rx[7:0], expRx);
        rxOut = rx[7:0];
    endtask

    initial begin
        logic [7:0]   rx8;
        logic [15:0]  rx16;
        logic [319:0] exp2;
        for (int r = 0; r < NR; r++) expRegs[r] = 8'h00;
        waitClk(4);
        rst = 1'b0;
        waitClk(6);

        checkOutput("rstRegs", regs_out, 40'h0);
        checkOutput("rstWrPulse", wr_pulse, 1'b0);
        checkOutput("rstFrameErr", frame_err, 1'b0);
        checkOutput("rstWrAddr", wr_addr, 7'd0);
        checkOutput("rstCipo", cipo, 1'b0);
        checkEn = 1'b1;

        applyStimulus(1'b1, 7'd2, 8'hA5, FL, rx8);
        checkOutput("reg2Lit", regs_out[23:16], 8'hA5);
        checkOutput("reg2AllLit", regs_out, 40'h0000A50000);
        checkOutput("reg2PulseLit", wrCount, 1);
        checkOutput("reg2AddrLit", wr_addr, 7'd2);

        applyStimulus(1'b1, 7'd7, 8'hFF, FL, rx8);
        checkOutput("badAddrLit", regs_out, 40'h0000A50000);
        checkOutput("badAddrErrLit", errCount, 1);
        checkOutput("badAddrPulseLit", wrCount, 1);

        applyStimulus(1'b1, 7'd1, 8'h77, 12, rx8);
        applyStimulus(1'b1, 7'd1, 8'h77, 17, rx8);
        checkOutput("shortLongErrLit", errCount, 3);
        checkOutput("shortLongRegsLit", regs_out, 40'h0000A50000);

        applyStimulus(1'b1, 7'd1, 8'h81, FL, rx8);
        applyStimulus(1'b1, 7'd0, 8'h11, FL, rx8);
        applyStimulus(1'b1, 7'd3, 8'hC3, FL, rx8);
        applyStimulus(1'b1, 7'd4, 8'h5A, FL, rx8);
        checkOutput("allRegsLit", regs_out, 40'h5AC3A58111);

        applyStimulus(1'b0, 7'd4, 8'h00, FL, rx8);
`ifdef SPI_READBACK_EN
        checkOutput("read4Lit", rx8, 8'h5A);
`else
        checkOutput("read4Lit", rx8, 8'h00);
`endif
        applyStimulus(1'b0, 7'd9, 8'h00, FL, rx8);
        checkOutput("read9Lit", rx8, 8'h00);
        applyStimulus(1'b0, 7'd2, 8'h00, FL, rx8);
        checkOutput("readErrLit", errCount, 3);

        setCs(0, 1'b0);
        waitClk(HALF);
        spiBits(0, {8'h00, 1'b1, 7'd1, 8'hEE}, 10, FL, rx16);
        checkEn = 1'b0;
        rst = 1'b1;
        waitClk(3);
        rst = 1'b0;
        waitClk(2);
        setCs(0, 1'b1);
        waitClk(SETTLE);
        for (int r = 0; r < NR; r++) expRegs[r] = 8'h00;
        expWrAddr = 7'd0;
        checkEn = 1'b1;
        checkOutput("midRstRegsLit", regs_out, 40'h0);
        checkOutput("midRstErr", errCount, expErr);

        applyStimulus(1'b1, 7'd0, 8'h3C, FL, rx8);
        checkOutput("reg0AfterRstLit", regs_out, 40'h000000003C);

        setCs(1, 1'b0);
        waitClk(HALF);
        spiBits(1, {1'b1, 7'd19, 16'hBEEF}, 24, 24, rx16);
        setCs(1, 1'b1);
        waitClk(SETTLE);
        exp2 = '0;
        exp2[319:304] = 16'hBEEF;
        checkOutput("wide19Lit", regs_out2[319:304], 16'hBEEF);
        checkOutput("wideAllLit", regs_out2, exp2);
        checkOutput("widePulseLit", wrCount2, 1);
        checkOutput("wideErrLit", errCount2, 0);
        checkOutput("wideAddrLit", wr_addr2, 7'd19);

        waitClk(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
